max7219_chain_tx: RTL and testbench
===================================

# max7219_chain_tx

Parametrised serial transmitter for one or more MAX7219 LED drivers daisy-chained on a single CS/CLK/Din bus. It runs entirely on `sys_clk` and uses a cycle-count divider, so it needs no derived clock. One `start` pulse latches a full frame holding one 16-bit command per device. The block shifts the frame out MSB-first, latches it with a CS rising edge, and reports completion with a `done` pulse. It sits between the display controller FSM and the board pins, and replaces the single-device transmitter.

## Interface
Parameters:
- `N_DEV`, default 4: number of chained MAX7219 devices, minimum 1. Frame width W = 16*N_DEV.
- `CLK_DIV`, default 6: `sys_clk` cycles per SPI CLK half-period, minimum 1.

Ports:
- `sys_clk`, input, 1: system clock. All logic is on its rising edge.
- `_rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: frame request. Sampled only while the FSM is in IDLE.
- `frame_in`, input, W: frame contents. Bits [W-1:W-16] hold {addr[7:0], data[7:0]} for the farthest device (last in the chain). Bits [15:0] hold the command for the device nearest the FPGA.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `done`, output, 1: one-cycle pulse when a frame completes.
- `CS`, output, 1: chip select, active low.
- `CLK`, output, 1: SPI clock.
- `Din`, output, 1: SPI data.

## Operation
- Reset values: `CS`=1, `CLK`=0, `Din`=0, `done`=0, `busy`=0, state IDLE, counters at 0.
- FSM states: IDLE, CLK_LO, CLK_HI, LATCH, GAP.
- IDLE, when `start`=1:
  - Latch `frame_in` into shift register `sr`.
  - Bit counter = W-1, divider = 0.
  - `CS`<=0, `Din`<=`frame_in`[W-1].
  - Next state CLK_LO.
- CLK_LO: hold `CLK`=0 for CLK_DIV cycles, then `CLK`<=1 and go to CLK_HI.
- CLK_HI: hold `CLK`=1 for CLK_DIV cycles, then `CLK`<=0.
  - If bits remain: shift `sr` left, drive the next MSB on `Din` in the same cycle as the CLK falling edge, decrement the bit counter, go to CLK_LO.
  - Otherwise: `Din`<=0, go to LATCH.
- LATCH: hold `CS`=0 with `CLK`=0 for CLK_DIV cycles, then `CS`<=1 and go to GAP.
- GAP: hold `CS`=1 for CLK_DIV cycles (minimum CS-high time), then go to IDLE with `done`<=1.
- `done` is registered. It is high for exactly the first IDLE cycle after GAP and 0 otherwise.
- `start` asserted while `busy`=1 is ignored, not queued. Changes to `frame_in` while busy have no effect.
- `start` in the same cycle as `done` is accepted, giving back-to-back frames.
- Reset mid-frame returns all outputs to their reset values immediately. The frame is aborted and no `done` is produced.
- The divider counter is $clog2(CLK_DIV+1) bits wide. The bit counter is $clog2(W) bits wide (minimum 1).

## Timing
- Latency from `start` sampled at edge t0:
  - t0+1: `CS`=0, `Din`=bit W-1, `busy`=1.
  - Rising CLK edge for bit k (k=0 is the first bit sent): t0+1+CLK_DIV*(2k+1).
  - Falling CLK edge for bit k: t0+1+CLK_DIV*(2k+2).
- `Din` changes only at CLK falling edges or at frame start. This guarantees CLK_DIV cycles of setup and hold around each rising edge.
- `CS` rises at t0+1+CLK_DIV*(2W+1).
- `done`=1 and `busy`=0 at t0+1+CLK_DIV*(2W+2).
- Exactly W rising CLK edges occur per frame. `CLK` is 0 whenever `CS`=1.

## Test plan
- Reset, then idle for 20 cycles: `CS`=1, `CLK`=0, `Din`=0, `busy`=0, `done`=0 throughout.
- N_DEV=1, CLK_DIV=2, `frame_in`=16'h0C01 with a single `start` at t0:
  - Bits sampled on CLK rising edges equal 0000_1100_0000_0001.
  - `CS` rises at t0+67 and `done` pulses at t0+69 only.
- N_DEV=4, CLK_DIV=1, `frame_in`=64'h0901_0A0F_0B07_0C01:
  - Exactly 64 rising edges, with the first 16 bits = 16'h0901.
  - `busy` is high for 130 cycles.
- `start` held high continuously, N_DEV=1, CLK_DIV=1:
  - Frames run back to back, each `done` cycle immediately followed by `CS`=0.
  - `frame_in` toggled mid-frame does not alter the transmitted bits.
- Assert `_rst` during bit 5 of a frame:
  - Outputs return to reset values asynchronously, with no `done`.
  - After release, a new `start` transmits a correct, complete frame.
- CLK_DIV=3 sweep: `Din` is stable for at least 3 cycles before and after every CLK rising edge. CLK high and low times are exactly 3 cycles each.

Source files
------------

// File: rtl/max7219_chain_tx.sv
// Serial transmitter for a daisy chain of MAX7219 drivers sharing one CS/CLK/Din bus.
// One start pulse shifts a 16*N_DEV-bit frame out MSB-first on a sys_clk-derived SPI clock, then latches it with CS.
module max7219_chain_tx #(
  parameter int N_DEV   = 4,
  parameter int CLK_DIV = 6
) (
  input  logic                sys_clk,
  input  logic                _rst,
  input  logic                start,
  input  logic [16*N_DEV-1:0] frame_in,
  output logic                busy,
  output logic                done,
  output logic                CS,
  output logic                CLK,
  output logic                Din
);

  localparam int W     = 16 * N_DEV;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = (W > 1) ? $clog2(W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLK_LO,
    CLK_HI,
    LATCH,
    GAP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  // The frame MSB goes straight to Din at start, so only the remaining W-1 bits are held here.
  logic [W-2:0]     sr;
  logic             div_end;

  assign div_end = (div_cnt == DIV_LAST);

  // NOTE: every register here is updated with non-blocking assignments, so all
  // decisions in one cycle see the pre-edge values of state, counters and sr.
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      CS      <= 1'b1;
      CLK     <= 1'b0;
      Din     <= 1'b0;
    end else begin
      done <= 1'b0;

      // Each timed phase lasts CLK_DIV cycles; the divider wraps as the phase ends.
      if (state != IDLE) begin
        div_cnt <= div_end ? '0 : div_cnt + DIV_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            sr      <= frame_in[W-2:0];
            bit_cnt <= BIT_LAST;
            div_cnt <= '0;
            CS      <= 1'b0;
            Din     <= frame_in[W-1];
            busy    <= 1'b1;
            state   <= CLK_LO;
          end
        end

        CLK_LO: begin
          if (div_end) begin
            CLK   <= 1'b1;
            state <= CLK_HI;
          end
        end

        CLK_HI: begin
          if (div_end) begin
            CLK <= 1'b0;
            // Din moves only on the falling edge, giving CLK_DIV cycles of setup and hold.
            if (bit_cnt != '0) begin
              Din     <= sr[W-2];
              sr      <= {sr[W-3:0], 1'b0};
              bit_cnt <= bit_cnt - BIT_W'(1);
              state   <= CLK_LO;
            end else begin
              Din   <= 1'b0;
              state <= LATCH;
            end
          end
        end

        LATCH: begin
          if (div_end) begin
            CS    <= 1'b1;
            state <= GAP;
          end
        end

        GAP: begin
          if (div_end) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_chain_tx.sv
// Scoreboard bench for max7219_chain_tx: a cycle-level acceptance model queues expected frames,
// and a pin monitor reconstructs each frame from CS/CLK/Din and checks its bits and timing.
module tb_max7219_chain_tx;

  localparam int N_DEV      = 2;
  localparam int CLK_DIV    = 3;
  localparam int W          = 16 * N_DEV;
  localparam int FRAME_CYC  = CLK_DIV * (2 * W + 2);
  localparam int CS_RISE    = 1 + CLK_DIV * (2 * W + 1);
  localparam int DONE_REL   = 1 + FRAME_CYC;
  localparam int CLK_PERIOD = 10;

  logic         sys_clk;
  logic         _rst;
  logic         start;
  logic [W-1:0] frame_in;
  logic         busy;
  logic         done;
  logic         CS;
  logic         CLK;
  logic         Din;

  max7219_chain_tx #(
    .N_DEV  (N_DEV),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .sys_clk (sys_clk),
    ._rst    (_rst),
    .start   (start),
    .frame_in(frame_in),
    .busy    (busy),
    .done    (done),
    .CS      (CS),
    .CLK     (CLK),
    .Din     (Din)
  );

  initial sys_clk = 1'b0;
  always #(CLK_PERIOD / 2) sys_clk = ~sys_clk;

  typedef struct {
    logic [W-1:0] frame;
    longint       t0;
  } exp_t;

  exp_t   exp_q[$];
  longint cyc     = 0;
  longint free_at = 0;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_frame();
    logic [W-1:0] f;
    for (int i = 0; i < N_DEV; i++) f[16*i +: 16] = 16'($urandom);
    return f;
  endfunction

  // Acceptance model: a start seen while the transmitter is free launches a frame
  // that occupies FRAME_CYC cycles; the done cycle itself can accept the next one.
  always @(posedge sys_clk) begin
    cyc++;
    if (_rst && start && cyc >= free_at) begin
      exp_q.push_back('{frame: frame_in, t0: cyc});
      free_at = cyc + FRAME_CYC + 1;
    end
  end

  always @(negedge _rst) begin
    exp_q.delete();
    free_at = 0;
  end

  // Pin monitor.
  exp_t         cur;
  logic         in_frame = 1'b0;
  logic         prev_cs = 1'b1, prev_clk = 1'b0, prev_din = 1'b0;
  logic [W-1:0] rx;
  int           rel, rises, busy_cnt, edge_viol, sh_viol, cs_rise_rel;
  int           last_din, last_rise, last_fall;
  int           cs_clk_viol = 0;
  int           frames_done = 0;

  always @(negedge sys_clk) begin
    if (!_rst) begin
      in_frame = 1'b0;
      prev_cs  = 1'b1;
      prev_clk = 1'b0;
      prev_din = 1'b0;
    end else begin
      if (CS && CLK) cs_clk_viol++;
      if (done) begin
        check("done_expected", in_frame, 1);
        if (in_frame) begin
          rel = int'(cyc - cur.t0) + 1;
          check("frame_bits", rx, cur.frame);
          check("rise_count", rises, W);
          check("cs_rise_time", cs_rise_rel, CS_RISE);
          check("done_time", rel, DONE_REL);
          check("busy_cycles", busy_cnt, FRAME_CYC);
          check("clk_edge_timing_errs", edge_viol, 0);
          check("din_setup_hold_errs", sh_viol, 0);
          check("done_levels", {CS, CLK, Din, busy}, 4'b1000);
          in_frame = 1'b0;
          frames_done++;
        end
      end else if (prev_cs && !CS) begin
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur         = exp_q.pop_front();
          in_frame    = 1'b1;
          rx          = '0;
          rises       = 0;
          edge_viol   = 0;
          sh_viol     = 0;
          cs_rise_rel = 0;
          rel         = int'(cyc - cur.t0) + 1;
          check("cs_fall_time", rel, 1);
          check("first_bit", Din, cur.frame[W-1]);
          busy_cnt  = busy ? 1 : 0;
          last_din  = rel;
          last_fall = rel;
          last_rise = 0;
        end
      end else if (in_frame) begin
        rel = int'(cyc - cur.t0) + 1;
        if (busy) busy_cnt++;
        if (!prev_clk && CLK) begin
          if (rel != 1 + CLK_DIV * (2 * rises + 1)) edge_viol++;
          if (rel - last_fall != CLK_DIV) edge_viol++;
          if (rel - last_din < CLK_DIV) sh_viol++;
          rx = {rx[W-2:0], Din};
          rises++;
          last_rise = rel;
        end
        if (prev_clk && !CLK) begin
          if (rel != 1 + CLK_DIV * (2 * rises)) edge_viol++;
          if (rel - last_rise != CLK_DIV) edge_viol++;
          last_fall = rel;
        end
        if (Din != prev_din) begin
          if (!(prev_clk && !CLK)) sh_viol++;
          if (rel - last_rise < CLK_DIV) sh_viol++;
          last_din = rel;
        end
        if (!prev_cs && CS) cs_rise_rel = rel;
        if (rel > DONE_REL + 4) begin
          check("frame_timeout", rel, DONE_REL);
          in_frame = 1'b0;
        end
      end
      prev_cs  = CS;
      prev_clk = CLK;
      prev_din = Din;
    end
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || busy) && n < 4 * FRAME_CYC) begin
      @(negedge sys_clk);
      n++;
    end
    check("drain_in_time", n < 4 * FRAME_CYC, 1);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [W-1:0] f);
    @(negedge sys_clk);
    start    = 1'b1;
    frame_in = f;
    @(negedge sys_clk);
    start    = 1'b0;
    frame_in = rand_frame();
    drain();
  endtask

  initial begin
    #(100000 * CLK_PERIOD);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    _rst     = 1'b0;
    start    = 1'b0;
    frame_in = '0;
    repeat (3) @(negedge sys_clk);
    check("reset_outputs", {CS, CLK, Din, busy, done}, 5'b10000);
    _rst = 1'b1;

    bad = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if ({CS, CLK, Din, busy, done} !== 5'b10000) bad++;
    end
    check("idle_outputs_bad_cycles", bad, 0);

    // Directed frames, including all-zero/all-one and lone-edge-bit patterns.
    send_frame(W'(32'h0C01_0901));
    send_frame(W'(32'h0901_0A0F));
    send_frame('1);
    send_frame('0);
    send_frame(W'(32'h8000_0001));

    // Random start pulses, many landing while busy, with frame_in changing every cycle.
    repeat (6 * FRAME_CYC) begin
      @(negedge sys_clk);
      start    = ($urandom_range(0, 15) == 0);
      frame_in = rand_frame();
    end
    start = 1'b0;
    drain();

    // start held high: frames must run back to back.
    @(negedge sys_clk);
    start = 1'b1;
    repeat (3 * (FRAME_CYC + 1)) begin
      frame_in = rand_frame();
      @(negedge sys_clk);
    end
    start = 1'b0;
    drain();

    // Asynchronous reset while bit 5 is on the wire.
    @(negedge sys_clk);
    start    = 1'b1;
    frame_in = '1;
    @(negedge sys_clk);
    start    = 1'b0;
    frame_in = rand_frame();
    repeat (CLK_DIV * 11) @(negedge sys_clk);
    check("pre_reset_bit5_levels", {CS, CLK, Din}, 3'b011);
    #1 _rst = 1'b0;
    #1 check("async_reset_outputs", {CS, CLK, Din, busy, done}, 5'b10000);
    repeat (3) @(negedge sys_clk);
    check("held_reset_outputs", {CS, CLK, Din, busy, done}, 5'b10000);
    _rst = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("post_reset_idle", {CS, CLK, Din, busy, done}, 5'b10000);
    send_frame(rand_frame());
    send_frame(rand_frame());

    check("frames_pending", exp_q.size(), 0);
    check("clk_high_while_cs_high", cs_clk_viol, 0);
    check("frames_completed", frames_done >= 12, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
